// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LC-3b pipeline advance controller.
package pipe_ctrl_pkg;

   typedef logic [15:0] lc3b_word;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } pipe_ctrl_state_t;

   localparam lc3b_word lc3b_nop_cw = 16'h0000;
   localparam lc3b_word STALL_MAX   = 16'hFFFF;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// 16-bit saturating incrementer with asynchronous active-low clear.
module sat_counter
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [15:0] out
);

   lc3b_word cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != STALL_MAX)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline advance controller: latch enables, bubbles and flushes from cache handshakes and hazards.
//   state  | meaning
//   S_INIT | one cycle after reset, no requests, all outputs low
//   S_RUN  | normal operation, advance when both caches are satisfied
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_resp,
   input  logic        dmem_req,
   input  logic        dmem_resp,
   input  logic        load_use,
   input  logic        br_taken,
   output logic        imem_read,
   output logic        dmem_go,
   output logic        load_pc,
   output logic        load_if_id,
   output logic        load_id_ex,
   output logic        load_ex_mem,
   output logic        load_mem_wb,
   output logic        bubble_id_ex,
   output logic        flush,
   output logic        pcmux_br,
   output logic [15:0] stall_cnt
);

   pipe_ctrl_state_t state_q, state_d;
   logic imem_done_q, imem_done_d;
   logic dmem_done_q, dmem_done_d;
   logic run, i_ok, d_ok, adv;

   assign run  = (state_q == S_RUN);
   assign i_ok = imem_done_q | imem_resp;
   assign d_ok = !dmem_req | dmem_done_q | dmem_resp;
   assign adv  = run & i_ok & d_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         imem_done_q <= 1'b0;
         dmem_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         imem_done_q <= imem_done_d;
         dmem_done_q <= dmem_done_d;
      end
   end

   // A response only latches while its request is outstanding and the pipe is held.
   always_comb begin
      state_d     = S_RUN;
      imem_done_d = imem_done_q;
      dmem_done_d = dmem_done_q;
      if (adv) begin
         imem_done_d = 1'b0;
         dmem_done_d = 1'b0;
      end else if (run) begin
         if (imem_resp) imem_done_d = 1'b1;
         if (dmem_resp && dmem_req) dmem_done_d = 1'b1;
      end
   end

   always_comb begin
      imem_read    = run & !imem_done_q;
      dmem_go      = run & dmem_req & !dmem_done_q;
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      bubble_id_ex = 1'b0;
      flush        = 1'b0;
      pcmux_br     = 1'b0;
      if (adv) begin
         load_id_ex  = 1'b1;
         load_ex_mem = 1'b1;
         load_mem_wb = 1'b1;
         if (br_taken) begin
            load_pc    = 1'b1;
            load_if_id = 1'b1;
            flush      = 1'b1;
            pcmux_br   = 1'b1;
         end else if (load_use) begin
            bubble_id_ex = 1'b1;
         end else begin
            load_pc    = 1'b1;
            load_if_id = 1'b1;
         end
      end
   end

   sat_counter u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (run & !adv),
      .out   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected output vectors are queued per driven cycle and checked mid-cycle.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_resp, dmem_req, dmem_resp, load_use, br_taken;
   logic        imem_read, dmem_go;
   logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic        bubble_id_ex, flush, pcmux_br;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [25:0] v;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] st_exp;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_resp    (imem_resp),
      .dmem_req     (dmem_req),
      .dmem_resp    (dmem_resp),
      .load_use     (load_use),
      .br_taken     (br_taken),
      .imem_read    (imem_read),
      .dmem_go      (dmem_go),
      .load_pc      (load_pc),
      .load_if_id   (load_if_id),
      .load_id_ex   (load_id_ex),
      .load_ex_mem  (load_ex_mem),
      .load_mem_wb  (load_mem_wb),
      .bubble_id_ex (bubble_id_ex),
      .flush        (flush),
      .pcmux_br     (pcmux_br),
      .stall_cnt    (stall_cnt)
   );

   task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // vector: {loads[4:0] (pc,if_id,id_ex,ex_mem,mem_wb), bubble, flush, pcmux_br, imem_read, dmem_go, stall_cnt}
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.tag,
             {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
              bubble_id_ex, flush, pcmux_br, imem_read, dmem_go, stall_cnt},
             e.v);
      end
   end

   localparam logic [4:0] L_ALL = 5'b11111;
   localparam logic [4:0] L_LU  = 5'b00111;
   localparam logic [4:0] L_NO  = 5'b00000;

   // Drive one cycle's inputs just after the rising edge and queue the expected outputs.
   task automatic cyc(input string tag, input logic imr, input logic dq, input logic drs,
                      input logic lu, input logic br,
                      input logic [4:0] ld, input logic bub, input logic fl, input logic pcb,
                      input logic ir, input logic dg, input logic stl);
      exp_t e;
      imem_resp = imr;
      dmem_req  = dq;
      dmem_resp = drs;
      load_use  = lu;
      br_taken  = br;
      e.tag = tag;
      e.v   = {ld, bub, fl, pcb, ir, dg, st_exp};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (stl && st_exp != 16'hFFFF) st_exp = st_exp + 16'd1;
   endtask

   initial begin
      rst_n = 1'b0;
      imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; load_use = 1'b0; br_taken = 1'b0;
      st_exp = 16'd0;
      @(posedge clk); #1;
      cyc("in_reset", 1, 0, 0, 0, 0, L_NO, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc("init_cycle", 1, 0, 0, 0, 0, L_NO, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         cyc("zero_wait", 1, 0, 0, 0, 0, L_ALL, 0, 0, 0, 1, 0, 0);

      // imem first, dmem three cycles later
      cyc("ooo_t0", 1, 1, 0, 0, 0, L_NO,  0, 0, 0, 1, 1, 1);
      cyc("ooo_t1", 0, 1, 0, 0, 0, L_NO,  0, 0, 0, 0, 1, 1);
      cyc("ooo_t2", 0, 1, 0, 0, 0, L_NO,  0, 0, 0, 0, 1, 1);
      cyc("ooo_t3", 0, 1, 1, 0, 0, L_ALL, 0, 0, 0, 0, 1, 0);
      cyc("ooo_after", 1, 0, 0, 0, 0, L_ALL, 0, 0, 0, 1, 0, 0);

      // dmem first, imem two cycles later
      cyc("dfirst_t0", 0, 1, 1, 0, 0, L_NO,  0, 0, 0, 1, 1, 1);
      cyc("dfirst_t1", 0, 1, 0, 0, 0, L_NO,  0, 0, 0, 1, 0, 1);
      cyc("dfirst_t2", 1, 1, 0, 0, 0, L_ALL, 0, 0, 0, 1, 0, 0);
      cyc("both_same", 1, 1, 1, 0, 0, L_ALL, 0, 0, 0, 1, 1, 0);

      // load-use bubble, then re-fetch
      cyc("load_use",  1, 0, 0, 1, 0, L_LU,  1, 0, 0, 1, 0, 0);
      cyc("lu_refetch",1, 0, 0, 0, 0, L_ALL, 0, 0, 0, 1, 0, 0);

      // branch wins over load-use; branch without advance does nothing
      cyc("br_lu",     1, 0, 0, 1, 1, L_ALL, 0, 1, 1, 1, 0, 0);
      cyc("br_noadv",  0, 0, 0, 0, 1, L_NO,  0, 0, 0, 1, 0, 1);

      // duplicate imem response while its flag is set is ignored
      cyc("dup_t0", 1, 1, 0, 0, 0, L_NO,  0, 0, 0, 1, 1, 1);
      cyc("dup_t1", 1, 1, 0, 0, 0, L_NO,  0, 0, 0, 0, 1, 1);
      cyc("dup_t2", 0, 1, 1, 0, 0, L_ALL, 0, 0, 0, 0, 1, 0);

      // reset while dmem_done is set
      cyc("rstw_t0", 0, 1, 1, 0, 0, L_NO, 0, 0, 0, 1, 1, 1);
      cyc("rstw_t1", 0, 1, 0, 0, 0, L_NO, 0, 0, 0, 1, 0, 1);
      rst_n = 1'b0;
      st_exp = 16'd0;
      cyc("rstw_low", 1, 1, 0, 0, 0, L_NO, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc("rstw_init", 1, 1, 0, 0, 0, L_NO, 0, 0, 0, 0, 0, 0);
      cyc("rstw_need_d", 1, 1, 0, 0, 0, L_NO,  0, 0, 0, 1, 1, 1);
      cyc("rstw_dresp",  0, 1, 1, 0, 0, L_ALL, 0, 0, 0, 0, 1, 0);

      // saturation: 70000 cycles without any response
      imem_resp = 0; dmem_req = 0; dmem_resp = 0; load_use = 0; br_taken = 0;
      repeat (70000) @(posedge clk);
      #1;
      st_exp = 16'hFFFF;
      cyc("sat_hold", 0, 0, 0, 0, 0, L_NO, 0, 0, 0, 1, 0, 1);
      cyc("sat_hold2", 0, 0, 0, 0, 0, L_NO, 0, 0, 0, 1, 0, 1);
      #1;
      rst_n = 1'b0;
      st_exp = 16'd0;
      #1;
      chk("sat_async_clr", {10'd0, stall_cnt}, {10'd0, st_exp});
      cyc("sat_rst_low", 0, 0, 0, 0, 0, L_NO, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc("post_init", 1, 0, 0, 0, 0, L_NO,  0, 0, 0, 0, 0, 0);
      cyc("post_run",  1, 0, 0, 0, 0, L_ALL, 0, 0, 0, 1, 0, 0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline advance controller for the LC-3b pipeline. It is the control end of every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB): it decides each cycle whether the latches load, whether ID/EX receives a bubble, and whether younger stages are flushed. It tracks I-cache and D-cache handshakes, load-use hazards and taken branches, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- none; all widths are fixed (lc3b_word = 16 bits).

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- imem_resp  input  1  I-cache response; one-cycle pulse, fetch data valid
- dmem_req  input  1  EX/MEM control word holds a load or store; stable until the next advance
- dmem_resp  input  1  D-cache response; one-cycle pulse
- load_use  input  1  ID instruction sources the destination of a load in EX
- br_taken  input  1  MEM-stage branch, JMP, JSR or TRAP resolved taken
- imem_read  output  1  I-cache request
- dmem_go  output  1  D-cache request enable; gates the CW read/write bits
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  latch load enables
- bubble_id_ex  output  1  ID/EX loads a NOP control word (CW = 0)
- flush  output  1  IF/ID, ID/EX and EX/MEM load NOP
- pcmux_br  output  1  PC loads the branch target
- stall_cnt  output  16 (lc3b_word)  saturating count of non-advancing cycles

## Operation
- States: S_INIT and S_RUN. Reset forces S_INIT, which lasts exactly one cycle and then moves unconditionally to S_RUN. S_RUN never exits except on reset.
- Flags: imem_done and dmem_done, both 0 at reset.
- i_ok = imem_done | imem_resp.
- d_ok = !dmem_req | dmem_done | dmem_resp.
- adv = (state == S_RUN) & i_ok & d_ok.
- imem_read = S_RUN & !imem_done.
- dmem_go = S_RUN & dmem_req & !dmem_done.
- Flag updates:
  - A resp that arrives with !adv sets its flag.
  - adv clears both flags.
  - A resp arriving in the same cycle as adv does not set its flag.
- On adv, with priority from top to bottom:
  1. br_taken: all five loads = 1, flush = 1, pcmux_br = 1, bubble_id_ex = 0. load_use is ignored.
  2. load_use: load_pc = 0, load_if_id = 0, load_id_ex = 1 with bubble_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1. The fetched instruction is discarded, and the same PC is re-fetched on the next cycle.
  3. Otherwise: all five loads = 1, and flush, bubble_id_ex and pcmux_br are all 0.
- With !adv: all loads, flush, bubble_id_ex and pcmux_br are 0.
- stall_cnt: increments in every S_RUN cycle with !adv. It saturates at 0xFFFF, holds in S_INIT, and resets to 0.
- A resp whose request is not outstanding (flag already set, or no request) is ignored.

## Timing
- All outputs except stall_cnt are combinational from state, flags and inputs (Mealy). The latches load on the same edge on which adv is high.
- Zero-wait operation is one advance per cycle: two responses in the same cycle with both flags 0 give adv in that cycle.
- imem_resp at cycle t and dmem_resp at t+3: adv at t+3, with stall_cnt +3 (cycles t..t+2).
- dmem_resp at t and imem_resp at t+2: adv at t+2, with stall_cnt +2.
- imem_read drops in the cycle after an imem_resp that did not advance; dmem_go behaves the same way.
- Reset values: state = S_INIT, flags = 0, stall_cnt = 0. In S_INIT all outputs are 0.
- Reset mid-wait: outstanding requests are dropped. After rst_n rises there is one S_INIT cycle, then imem_read = 1.

## Structure
- lc3b_types gains pipe_ctrl_state_t (enum: S_INIT, S_RUN).
- lc3b_types gains lc3b_nop_cw (16'h0000).
- stall_cnt uses lc3b_word.
- One sub-module is natural: sat_counter. It is a 16-bit saturating incrementer with async active-low clear, inc input and out output.

## Test plan
- Reset release with imem_resp tied high and dmem_req = 0:
  - imem_read = 0 in the first cycle (S_INIT).
  - Then all loads are 1 every cycle, and stall_cnt stays at 0.
- Responses out of order (imem_resp at t, dmem_req = 1, dmem_resp at t+3):
  - adv occurs only at t+3; imem_read = 0 for t+1..t+3; stall_cnt = 3.
- load_use = 1 on an advancing cycle:
  - load_pc = 0, load_if_id = 0, bubble_id_ex = 1, load_ex_mem = 1.
  - imem_read = 1 on the next cycle.
- br_taken and load_use both 1 on an advancing cycle:
  - flush = 1, pcmux_br = 1, bubble_id_ex = 0, all loads = 1.
- 70000 cycles with no responses:
  - stall_cnt holds at 0xFFFF.
  - Asserting rst_n = 0 mid-cycle clears it to 0 immediately.
- rst_n pulsed low while dmem_done = 1:
  - After release both flags are 0, and a fresh dmem_resp is required before adv.
